// File: rtl/shift_issue_stage_pkg.sv
// Shared definitions for the shift issue stage: funct codes, shift-op encodings,
// buffer state encoding and the packed result entry.
package shift_issue_stage_pkg;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SLLV = 6'h04;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;
  localparam logic [5:0] FUNCT_SRAV = 6'h07;

  localparam logic [1:0] SHOP_SLL = 2'b00;
  localparam logic [1:0] SHOP_SRL = 2'b10;
  localparam logic [1:0] SHOP_SRA = 2'b11;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } state_e;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        illegal;
  } entry_t;

  function automatic logic funct_is_legal(input logic [5:0] funct);
    logic legal;
    case (funct)
      FUNCT_SLL, FUNCT_SRL, FUNCT_SRA,
      FUNCT_SLLV, FUNCT_SRLV, FUNCT_SRAV: legal = 1'b1;
      default:                            legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/shift_issue_stage_shifter.sv
// Combinational 32-bit barrel shifter: logical left, logical right, arithmetic right.
module shift_issue_stage_shifter
  import shift_issue_stage_pkg::*;
(
  input  logic [31:0] a,
  input  logic [4:0]  amount,
  input  logic [1:0]  op,
  output logic [31:0] result
);

  // Select the shift flavour; the unused encoding yields zero.
  always_comb begin
    result = 32'd0;
    case (op)
      SHOP_SLL: result = a << amount;
      SHOP_SRL: result = a >> amount;
      SHOP_SRA: result = $unsigned($signed(a) >>> amount);
      default:  result = 32'd0;
    endcase
  end

endmodule

// File: rtl/shift_issue_stage.sv
// Shift execute stage: decodes a MIPS shift, feeds the shifter and buffers results
// in a main/skid register pair. Define SHIFT_ISSUE_STATS_EN to add stat counters.
module shift_issue_stage
  import shift_issue_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_funct,
  input  logic [31:0] in_rs,
  input  logic [31:0] in_rt,
  input  logic [4:0]  in_shamt,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_illegal
`ifdef SHIFT_ISSUE_STATS_EN
  ,
  output logic [31:0] stat_ops,
  output logic [31:0] stat_illegal
`endif
);

  state_e      state_r, state_n_s;
  entry_t      m_r, s_r, entry_s;
  logic        in_ready_r;
  logic        accept_s, drain_s;
  logic        m_load_s, m_from_s_s, s_load_s;
  logic        legal_s;
  logic [4:0]  amount_s;
  logic [31:0] shift_y_s;
  logic        unused_rs_s;

  assign unused_rs_s = ^in_rs[31:5];

  // Variable shifts take the amount from rs, immediate shifts from shamt.
  assign amount_s = in_funct[2] ? in_rs[4:0] : in_shamt;
  assign legal_s  = funct_is_legal(in_funct);

  shift_issue_stage_shifter u_shifter (
    .a      (in_rt),
    .amount (amount_s),
    .op     (in_funct[1:0]),
    .result (shift_y_s)
  );

  assign entry_s.result  = legal_s ? shift_y_s : 32'd0;
  assign entry_s.rd      = in_rd;
  assign entry_s.illegal = ~legal_s;

  assign in_ready  = in_ready_r;
  assign out_valid = (state_r != ST_EMPTY);
  assign accept_s  = in_valid & in_ready_r;
  assign drain_s   = out_valid & out_ready;

  assign out_result  = m_r.result;
  assign out_rd      = m_r.rd;
  assign out_illegal = m_r.illegal;

  // Next-state and register-load decode for the main/skid buffer.
  always_comb begin
    state_n_s  = state_r;
    m_load_s   = 1'b0;
    m_from_s_s = 1'b0;
    s_load_s   = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          m_load_s  = 1'b1;
          state_n_s = ST_ONE;
        end else begin
          state_n_s = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (accept_s && drain_s) begin
          m_load_s  = 1'b1;
          state_n_s = ST_ONE;
        end else if (accept_s) begin
          s_load_s  = 1'b1;
          state_n_s = ST_TWO;
        end else if (drain_s) begin
          state_n_s = ST_EMPTY;
        end else begin
          state_n_s = ST_ONE;
        end
      end
      ST_TWO: begin
        if (drain_s) begin
          m_from_s_s = 1'b1;
          state_n_s  = ST_ONE;
        end else begin
          state_n_s = ST_TWO;
        end
      end
      default: state_n_s = ST_EMPTY;
    endcase
  end

  // State, upstream ready and the main/skid data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_EMPTY;
      in_ready_r <= 1'b1;
      m_r        <= '0;
      s_r        <= '0;
    end else begin
      state_r    <= state_n_s;
      in_ready_r <= (state_n_s != ST_TWO);
      if (m_from_s_s) begin
        m_r <= s_r;
      end else if (m_load_s) begin
        m_r <= entry_s;
      end
      if (s_load_s) begin
        s_r <= entry_s;
      end
    end
  end

`ifdef SHIFT_ISSUE_STATS_EN
  logic [31:0] stat_ops_r, stat_illegal_r;

  // Accept counters; both wrap naturally at 32 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops_r     <= 32'd0;
      stat_illegal_r <= 32'd0;
    end else if (accept_s) begin
      stat_ops_r <= stat_ops_r + 32'd1;
      if (!legal_s) begin
        stat_illegal_r <= stat_illegal_r + 32'd1;
      end
    end
  end

  assign stat_ops     = stat_ops_r;
  assign stat_illegal = stat_illegal_r;
`endif

endmodule

// File: doc/shift_issue_stage.md
# shift_issue_stage

Execute-stage wrapper that feeds the team's combinational shifter. It accepts one decoded MIPS shift instruction per cycle over a valid/ready handshake and selects the shifter operands and operation from the instruction fields. It registers the 32-bit result with a two-entry output buffer so that upstream ready is a flop output. It sits between the decode/operand-read stage and the writeback arbiter.

## Interface

Parameters:
- none. The data width is fixed at 32 and the shift amount at 5 bits.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream holds a valid instruction
- in_ready  out  1  stage can accept this cycle; driven directly from a flop
- in_funct  in  6  MIPS funct field
- in_rs  in  32  rs register value
- in_rt  in  32  rt register value, always the value being shifted
- in_shamt  in  5  shamt field
- in_rd  in  5  destination register tag
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts
- out_result  out  32  shifted value
- out_rd  out  5  destination tag
- out_illegal  out  1  funct was not a legal shift
- stat_ops  out  32  accepted-instruction count (only when compiled in)
- stat_illegal  out  32  accepted illegal-instruction count (only when compiled in)

## Operation

Decode is combinational on the input fields:
- Operand A is always in_rt.
- Shift amount B is in_rs[4:0] when funct[2]=1 (sllv/srlv/srav); otherwise it is in_shamt.
- The shift operation is funct[1:0]: 00 logical left, 10 logical right, 11 arithmetic right.
- Legal funct values: 0x00, 0x02, 0x03, 0x04, 0x06, 0x07.
- Any other funct is illegal, covering funct[5:3]≠0 or funct[1:0]=01. The stage then stores result 0 and out_illegal=1, and the entry still flows through normally.

Storage is a main register M (drives the out_* ports) plus a skid register S.

State machine:
- EMPTY (M empty, S empty)
  - accept → ONE
- ONE (M full, S empty)
  - accept without drain → TWO (new entry into S)
  - accept with drain → ONE (new entry into M)
  - drain without accept → EMPTY
- TWO (M full, S full)
  - in_ready=0, so no accept is possible
  - drain moves S into M → ONE

Handshake rules:
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- in_ready is the registered value of "S is empty next cycle".
- out_valid is 1 in ONE and TWO.
- While out_valid=1 and out_ready=0, out_result, out_rd and out_illegal stay stable.
- Ordering is strict FIFO. An entry in S never overtakes M.
- Upstream may change fields freely while in_ready=0; those fields are not sampled.

## Timing

- Latency: an instruction accepted at edge k appears on the out_* ports after edge k; out_valid=1 in cycle k+1 when the stage was EMPTY.
- Throughput: one instruction per cycle while out_ready=1.
- Reset values while rst_n=0 (asynchronous):
  - in_ready=1, out_valid=0
  - out_result=0, out_rd=0, out_illegal=0
  - stat counters 0
  - state EMPTY
- Reset mid-operation discards M and S. No partial output is produced after release.
- Simultaneous accept and drain in ONE sustains full rate without ever reaching TWO.
- Stat counters wrap from 0xFFFFFFFF to 0 and increment on accept only.

## Configuration

- Macro: SHIFT_ISSUE_STATS_EN.
- Defined: two 32-bit counters drive stat_ops and stat_illegal. stat_ops increments on every accept; stat_illegal increments on accepts with an illegal funct.
- Undefined: the counters and both stat ports are absent. All other behaviour is identical.

## Structure

- Shared package holds:
  - funct constants (SLL=6'h00, SRL=6'h02, SRA=6'h03, SLLV=6'h04, SRLV=6'h06, SRAV=6'h07)
  - the 2-bit shift-operation encodings
  - the state encoding (EMPTY/ONE/TWO)
  - the packed entry type {result, rd, illegal}
- One sub-module: the existing shifter, instantiated once on the decode side before the M/S registers. All buffering lives in shift_issue_stage.

## Test plan

- Reset release, then SLL rt=0x0000_0001 shamt=4 rd=3 with out_ready=1 → next cycle out_valid=1, out_result=0x0000_0010, out_rd=3, out_illegal=0.
- SRAV rt=0x8000_0000 rs=0x0000_0021 → out_result=0xC000_0000. Only rs[4:0]=1 is used.
- Funct 0x01 and funct 0x20 with rt=0xFFFF_FFFF → out_result=0, out_illegal=1 for each; stat_illegal=2 when compiled in.
- out_ready held 0 while 3 valid SRL ops are offered → two accepted, in_ready=0 from the cycle after the second accept. Outputs stay stable; after out_ready=1 the results drain in order and the third op is accepted.
- Back-to-back stream of 8 ops with out_ready=1 → one result per cycle, in_ready constantly 1, state never TWO.
- rst_n asserted while in TWO → out_valid=0 and in_ready=1 immediately; nothing is emitted after release.
